// File: rtl/traffic_generator.sv
// Per-PE packet source: injects a bounded stream of single-flit packets into a
// router Local input using the Req/Gnt/Full handshake.
module traffic_generator #(
  parameter logic [5:0] ModuleID     = 6'b000_000,
  parameter int         dataWidth    = 32,
  parameter int         dim          = 4,
  parameter int         INJ_INTERVAL = 8,
  parameter int         NUM_PACKETS  = 16,
  parameter int         DEST_MODE    = 0,
  parameter logic [5:0] DEST_ID      = 6'b000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic [dataWidth-1:0] PacketOut,
  output logic                 ReqDnStr,
  input  logic                 GntDnStr,
  input  logic                 DnStrFull,
  output logic [9:0]           SentCount,
  output logic                 Done
);

  localparam int                 CNT_W      = $clog2(INJ_INTERVAL + 1);
  localparam logic [CNT_W-1:0]   GAP_INIT   = CNT_W'(INJ_INTERVAL - 1);
  localparam logic [9:0]         PKT_TOTAL  = 10'(NUM_PACKETS);
  localparam logic [2:0]         COORD_MASK = 3'(dim - 1);
  localparam logic [5:0]         SEED_RAW   = ModuleID ^ 6'b101101;
  localparam logic [5:0]         LFSR_SEED  = (SEED_RAW == 6'd0) ? 6'd1 : SEED_RAW;

  typedef enum logic [1:0] {GAP, WAIT_GNT, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [5:0]           lfsr, lfsr_nxt;
  logic [dataWidth-1:0] packet_nxt;
  logic                 req_nxt;
  logic [9:0]           sent_nxt;
  logic                 done_nxt;

  // Random mode draws x and y from separate LFSR bit pairs; a draw that lands
  // on this PE is nudged to a neighbour so a node never targets itself.
  function automatic logic [5:0] pick_dest(input logic [1:0] hi, input logic [1:0] lo);
    logic [5:0] d;
    if (DEST_MODE == 0) begin
      d = DEST_ID;
    end else begin
      d = {COORD_MASK & {1'b0, hi}, COORD_MASK & {1'b0, lo}};
      if (d == ModuleID) d[0] = ~d[0];
    end
    return d;
  endfunction

  function automatic logic [5:0] lfsr_step(input logic [5:0] l);
    return {l[4:0], l[5] ^ l[4]};
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lfsr_nxt   = lfsr;
    packet_nxt = PacketOut;
    req_nxt    = ReqDnStr;
    sent_nxt   = SentCount;
    done_nxt   = Done;
    unique case (state)
      GAP: begin
        if (SentCount == PKT_TOTAL) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          req_nxt   = 1'b0;
        end else if (enable) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
          end else if (!DnStrFull) begin
            packet_nxt = dataWidth'({pick_dest(lfsr[4:3], lfsr[1:0]), SentCount, ModuleID});
            req_nxt    = 1'b1;
            state_nxt  = WAIT_GNT;
          end
        end
      end
      // A launched request is always carried to its grant; enable and Full
      // only gate the start of a packet.
      WAIT_GNT: begin
        if (GntDnStr) begin
          req_nxt  = 1'b0;
          sent_nxt = SentCount + 10'd1;
          lfsr_nxt = lfsr_step(lfsr);
          cnt_nxt  = GAP_INIT;
          if (SentCount + 10'd1 == PKT_TOTAL) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      DONE: begin
        done_nxt = 1'b1;
        req_nxt  = 1'b0;
      end
      default: state_nxt = GAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= GAP;
      cnt       <= GAP_INIT;
      lfsr      <= LFSR_SEED;
      PacketOut <= '0;
      ReqDnStr  <= 1'b0;
      SentCount <= 10'd0;
      Done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lfsr      <= lfsr_nxt;
      PacketOut <= packet_nxt;
      ReqDnStr  <= req_nxt;
      SentCount <= sent_nxt;
      Done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_generator.sv
// Bench for traffic_generator: two instances (fixed and random destination)
// checked against a behavioural model through launch/done scoreboards.
module tb_traffic_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rstn, en, full, gnt, req, dn;
  logic [1:0][31:0] pkt;
  logic [1:0][9:0]  sc;

  traffic_generator #(
    .ModuleID(6'b000_001), .dataWidth(32), .dim(4), .INJ_INTERVAL(4),
    .NUM_PACKETS(3), .DEST_MODE(0), .DEST_ID(6'b001_010)
  ) dut_a (
    .clk(clk), .reset(rstn[0]), .enable(en[0]), .PacketOut(pkt[0]), .ReqDnStr(req[0]),
    .GntDnStr(gnt[0]), .DnStrFull(full[0]), .SentCount(sc[0]), .Done(dn[0])
  );

  traffic_generator #(
    .ModuleID(6'b000_000), .dataWidth(32), .dim(4), .INJ_INTERVAL(2),
    .NUM_PACKETS(64), .DEST_MODE(1), .DEST_ID(6'b000_000)
  ) dut_b (
    .clk(clk), .reset(rstn[1]), .enable(en[1]), .PacketOut(pkt[1]), .ReqDnStr(req[1]),
    .GntDnStr(gnt[1]), .DnStrFull(full[1]), .SentCount(sc[1]), .Done(dn[1])
  );

  typedef struct packed { int cyc; int word; } ev_t;
  ev_t lq0[$], lq1[$], dq0[$], dq1[$];

  int P_I[2]    = '{4, 2};
  int P_N[2]    = '{3, 64};
  int P_MID[2]  = '{1, 0};
  int P_MODE[2] = '{0, 1};
  int P_DEST[2] = '{'h0A, 0};

  // model: phase 0 = gap, 1 = waiting for grant, 2 = finished
  int m_phase[2], m_en[2], m_sent[2], m_lfsr[2], m_last[2], ecnt[2];
  int age[2], dly[2], prev_req[2], prev_done[2];
  bit rand_dly[2], spur[2];
  bit rand_a;
  int checks = 0, errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_next(int l);
    return ((l << 1) | (((l >> 5) ^ (l >> 4)) & 1)) & 63;
  endfunction

  function automatic int dest_of(int i);
    int d;
    if (P_MODE[i] == 0) return P_DEST[i];
    d = (((m_lfsr[i] >> 3) & 3) << 3) | (m_lfsr[i] & 3);
    if (d == P_MID[i]) d = d ^ 1;
    return d;
  endfunction

  task automatic push_l(int i, int cyc, int word);
    ev_t e;
    e.cyc = cyc; e.word = word;
    if (i == 0) lq0.push_back(e); else lq1.push_back(e);
  endtask

  task automatic push_d(int i, int cyc, int cnt);
    ev_t e;
    e.cyc = cyc; e.word = cnt;
    if (i == 0) dq0.push_back(e); else dq1.push_back(e);
  endtask

  task automatic model_reset(int i);
    m_phase[i] = 0; m_en[i] = 0; m_sent[i] = 0; m_last[i] = 0; ecnt[i] = 0;
    m_lfsr[i] = P_MID[i] ^ 'h2D;
    if (m_lfsr[i] == 0) m_lfsr[i] = 1;
    if (i == 0) begin lq0.delete(); dq0.delete(); end
    else begin lq1.delete(); dq1.delete(); end
  endtask

  // One clock edge of the reference behaviour, using the inputs presented at that edge.
  task automatic model_edge(int i);
    case (m_phase[i])
      0: begin
        if (m_sent[i] == P_N[i]) begin
          m_phase[i] = 2;
          push_d(i, ecnt[i], m_sent[i]);
        end else if (en[i]) begin
          if (m_en[i] >= P_I[i] - 1 && !full[i]) begin
            m_last[i] = (dest_of(i) << 16) | (m_sent[i] << 6) | P_MID[i];
            push_l(i, ecnt[i], m_last[i]);
            m_phase[i] = 1;
          end else begin
            m_en[i]++;
          end
        end
      end
      1: begin
        if (gnt[i]) begin
          m_sent[i]++;
          m_lfsr[i] = lfsr_next(m_lfsr[i]);
          m_en[i] = 0;
          if (m_sent[i] == P_N[i]) begin
            m_phase[i] = 2;
            push_d(i, ecnt[i], m_sent[i]);
          end else begin
            m_phase[i] = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  // Advance one cycle; the sink grants dly cycles after it first sees Req.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) if (rstn[i]) begin ecnt[i]++; model_edge(i); end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (req[i]) age[i]++; else age[i] = 0;
      if (age[i] == 1 && rand_dly[i]) dly[i] = $urandom_range(1, 4);
      gnt[i] = (req[i] && age[i] == dly[i] + 1) ||
               (!req[i] && spur[i] && $urandom_range(0, 5) == 0);
    end
    en[1]   = ($urandom_range(0, 9) != 0);
    full[1] = ($urandom_range(0, 4) == 0);
    if (rand_a) begin
      en[0]   = ($urandom_range(0, 7) != 0);
      full[0] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic check_reset_vals(int i, string tag);
    check({tag, "_pkt"},  pkt[i], 32'd0);
    check({tag, "_req"},  {31'd0, req[i]}, 32'd0);
    check({tag, "_sent"}, {22'd0, sc[i]}, 32'd0);
    check({tag, "_done"}, {31'd0, dn[i]}, 32'd0);
  endtask

  task automatic do_reset(int i);
    rstn[i] = 1'b0;
    #1;
    check_reset_vals(i, "rst");
    model_reset(i);
    en[i] = 1'b1; full[i] = 1'b0; gnt[i] = 1'b0;
    tick(); tick();
    rstn[i] = 1'b1;
  endtask

  // Monitor: live state against the model, plus scoreboard pops on Req/Done rises.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn[i]) begin
        prev_req[i] = 0; prev_done[i] = 0;
      end else begin
        string p;
        ev_t e;
        p = (i == 0) ? "a_" : "b_";
        check({p, "live_req"},  {31'd0, req[i]}, (m_phase[i] == 1) ? 32'd1 : 32'd0);
        check({p, "live_done"}, {31'd0, dn[i]},  (m_phase[i] == 2) ? 32'd1 : 32'd0);
        check({p, "live_sent"}, {22'd0, sc[i]},  m_sent[i]);
        check({p, "live_pkt"},  pkt[i],          m_last[i]);
        if (req[i] && prev_req[i] == 0) begin
          if ((i == 0 ? lq0.size() : lq1.size()) == 0) begin
            check({p, "launch_unexpected"}, 32'd1, 32'd0);
          end else begin
            e = (i == 0) ? lq0.pop_front() : lq1.pop_front();
            check({p, "launch_cycle"}, ecnt[i], e.cyc);
            check({p, "launch_word"},  pkt[i],  e.word);
            if (i == 1)
              check("b_dest_range",
                    {31'd0, (pkt[i][21:19] <= 3'd3 && pkt[i][18:16] <= 3'd3 &&
                             pkt[i][21:16] != 6'd0)}, 32'd1);
          end
        end
        if (dn[i] && prev_done[i] == 0) begin
          if ((i == 0 ? dq0.size() : dq1.size()) == 0) begin
            check({p, "done_unexpected"}, 32'd1, 32'd0);
          end else begin
            e = (i == 0) ? dq0.pop_front() : dq1.pop_front();
            check({p, "done_cycle"}, ecnt[i], e.cyc);
            check({p, "done_count"}, {22'd0, sc[i]}, e.word);
          end
        end
        prev_req[i] = req[i]; prev_done[i] = dn[i];
      end
    end
  end

  initial begin
    int n;
    rstn = 2'b00; en = 2'b11; full = 2'b00; gnt = 2'b00;
    rand_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      age[i] = 0; dly[i] = 1; rand_dly[i] = (i == 1); spur[i] = (i == 1);
      prev_req[i] = 0; prev_done[i] = 0;
      model_reset(i);
    end
    tick(); tick(); tick();
    check_reset_vals(0, "init_a");
    check_reset_vals(1, "init_b");
    rstn = 2'b11;

    // Fixed destination, grant one cycle after Req, three packets.
    n = 0;
    while (m_phase[0] != 2 && n < 200) begin tick(); n++; end
    tick(); tick(); tick();
    check("t1_sent", {22'd0, sc[0]}, 32'd3);
    check("t1_done", {31'd0, dn[0]}, 32'd1);
    check("t1_last_word", pkt[0], 32'h000A0081);

    // Full held for 10 cycles across the first injection point.
    do_reset(0);
    tick(); tick(); tick();
    full[0] = 1'b1;
    repeat (10) tick();
    full[0] = 1'b0;
    n = 0;
    while (m_phase[0] != 1 && n < 20) begin tick(); n++; end
    tick();
    check("t2_req_after_full", {31'd0, req[0]}, 32'd1);

    // Slow grant with Full toggling while the request is pending.
    dly[0] = 5;
    do_reset(0);
    n = 0;
    while (!req[0] && n < 50) begin tick(); n++; end
    n = 0;
    while (req[0] && n < 30) begin full[0] = ~full[0]; tick(); n++; end
    full[0] = 1'b0;
    check("t3_one_packet", {22'd0, sc[0]}, 32'd1);
    dly[0] = 1;

    // enable dropped for 7 cycles in the middle of a gap.
    do_reset(0);
    n = 0;
    while (m_sent[0] != 1 && n < 50) begin tick(); n++; end
    tick();
    en[0] = 1'b0;
    repeat (7) tick();
    en[0] = 1'b1;
    n = 0;
    while (m_sent[0] != 2 && n < 50) begin tick(); n++; end
    check("t4_sent", {22'd0, sc[0]}, 32'd2);

    // Asynchronous reset while the third request is pending.
    dly[0] = 3;
    do_reset(0);
    n = 0;
    while (!(m_sent[0] == 2 && req[0]) && n < 200) begin tick(); n++; end
    check("t5_in_wait", {31'd0, req[0]}, 32'd1);
    rstn[0] = 1'b0;
    #1;
    check("t5_async_req",  {31'd0, req[0]}, 32'd0);
    check("t5_async_sent", {22'd0, sc[0]}, 32'd0);
    model_reset(0);
    tick(); tick();
    rstn[0] = 1'b1;
    dly[0] = 1;
    n = 0;
    while (m_phase[0] != 1 && n < 50) begin tick(); n++; end
    tick();
    check("t5_packet_id", {22'd0, pkt[0][15:6]}, 32'd0);

    // Randomised enable/Full/grant timing with spurious grants.
    rand_a = 1'b1; rand_dly[0] = 1'b1; spur[0] = 1'b1;
    repeat (3) begin
      do_reset(0);
      repeat (90) tick();
    end
    rand_a = 1'b0; en[0] = 1'b1; full[0] = 1'b0;

    n = 0;
    while (!dn[1] && n < 3000) begin tick(); n++; end
    tick(); tick(); tick();
    check("b_done",  {31'd0, dn[1]}, 32'd1);
    check("b_sent",  {22'd0, sc[1]}, 32'd64);
    check("a_done_final", {31'd0, dn[0]}, 32'd1);
    check("a_launch_left", lq0.size(), 32'd0);
    check("b_launch_left", lq1.size(), 32'd0);
    check("done_left", dq0.size() + dq1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
